// File: rtl/rca_seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents: operand width, iteration counter width, index of the last adder
// iteration, and the FSM state encoding.
package mul_pkg;

  localparam int W         = 16;
  localparam int CNT_W     = 5;
  localparam int LAST_ITER = W - 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/rca_seq_mult_rca.sv
// 16-bit ripple-carry adder row, carry-in tied to zero.
// Ports:
//   a, b  : 16-bit addends
//   s     : 16-bit sum
//   cout  : carry out of the top bit
module rca_seq_mult_rca
  import mul_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[16];

endmodule

// File: rtl/rca_seq_mult.sv
// Sequential 16x16 unsigned shift-add multiplier. One 16-bit ripple-carry row
// is reused for 16 iterations; the product appears 16 edges after the operand
// handshake and is held until the consumer takes it.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operand pair a/b valid
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : 16-bit unsigned multiplicand / multiplier
//   out_valid : product on s valid (DONE)
//   out_ready : consumer accepts product
//   s         : 32-bit unsigned product, held until the next completion
//   busy      : high while an operation is in RUN or DONE
module rca_seq_mult
  import mul_pkg::*;
#(
  parameter int W     = mul_pkg::W,
  parameter int CNT_W = mul_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] s,
  output logic           busy
);

  // The adder row is a fixed 16-bit macro, so the datapath cannot be resized.
  if (W != 16 || CNT_W < 4) begin : g_param_check
    $error("rca_seq_mult: W must be 16 and CNT_W at least 4");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     areg;
  logic [2*W-1:0]   preg;

  logic [W-1:0]     addend;
  logic [W-1:0]     sum;
  logic             co;
  logic [2*W-1:0]   p_next;

  // Upper half of P accumulates partial products, lower half holds the
  // not-yet-consumed multiplier bits; each iteration shifts both right by one.
  assign addend = preg[0] ? areg : '0;
  assign p_next = {co, sum, preg[W-1:1]};

  rca_seq_mult_rca u_rca (
    .a    (preg[2*W-1:W]),
    .b    (addend),
    .s    (sum),
    .cout (co)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      areg  <= '0;
      preg  <= '0;
      s     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            areg  <= a;
            preg  <= {{W{1'b0}}, b};
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          preg <= p_next;
          if (cnt == CNT_W'(LAST_ITER)) begin
            // Final iteration: publish the completed product directly.
            s     <= p_next;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_mult.sv
module tb_rca_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_seq_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Drives one operation with out_ready held high; returns product and the
  // number of edges from accept to out_valid (-1 if it never came).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        res = s;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b s=%h busy=%b required 0/0/0", out_valid, s, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h0003, 16'hFFFF, 16'h1234, 16'h0000};
    logic [15:0] vb [4] = '{16'h0005, 16'hFFFF, 16'h0000, 16'hBEEF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== ref_mul(va[i], vb[i])) begin
        errors++;
        $display("FAIL directed_product[%0d]: got %h required %h", i, res, ref_mul(va[i], vb[i]));
      end
      checks++;
      if (lat !== 16) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required 16", i, lat);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_return_idle[%0d]: in_ready=%b busy=%b out_valid=%b required 1/0/0",
                 i, in_ready, busy, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] ta = 16'hA5C3;
    logic [15:0] tb_v = 16'h3C5A;
    logic [31:0] exp_p = ref_mul(ta, tb_v);
    logic [31:0] res;
    int lat;
    bit seen = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_out_valid_timeout: got 0 required 1");
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'(c % 2);
      a = $urandom; b = $urandom;
      #1;
      checks++;
      if (out_valid !== 1'b1 || s !== exp_p || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out_valid=%b s=%h in_ready=%b busy=%b required 1/%h/0/1",
                 c, out_valid, s, in_ready, busy, exp_p);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== exp_p) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b s=%h required 0/1/%h",
               out_valid, in_ready, s, exp_p);
    end
    run_op(16'h0101, 16'h0202, res, lat);
    checks++;
    if (res !== 32'h00020402 || lat !== 16) begin
      errors++;
      $display("FAIL stall_followup: got %h lat %0d required 00020402 lat 16", res, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h7777; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: out_valid=%b s=%h busy=%b required 0/0/0", out_valid, s, busy);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_release: in_ready=%b out_valid=%b s=%h required 1/0/0", in_ready, out_valid, s);
    end
    run_op(16'd7, 16'd9, res, lat);
    checks++;
    if (res !== 32'd63 || lat !== 16) begin
      errors++;
      $display("FAIL async_reset_next_op: got %0d lat %0d required 63 lat 16", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    bit hs_in = 1'b0;
    bit hs_out;
    logic [31:0] e;
    a = $urandom; b = $urandom;
    while (recv < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (hs_in) begin a = $urandom; b = $urandom; end
      in_valid  = (sent < 1000);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_output: got %h required none", s);
        end else begin
          e = expq.pop_front();
          if (s !== e) begin
            errors++;
            $display("FAIL b2b_product[%0d]: got %h required %h", recv, s, e);
          end
        end
        recv++;
      end
      if (hs_in) begin
        expq.push_back(ref_mul(a, b));
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 1000 || sent !== 1000 || expq.size() !== 0) begin
      errors++;
      $display("FAIL b2b_counts: sent %0d recv %0d pending %0d required 1000/1000/0",
               sent, recv, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
